// File: rtl/seq_match_monitor.sv
// Purpose : gap-statistics monitor. It counts match pulses and queues the
//           cycle distance between consecutive matches.
// Latency : match_cnt updates on the edge that samples seq. A gap entry is
//           visible on gap_valid the cycle after the pushing edge.
// Backpr. : gap_ready stalls the head entry. A push into a full FIFO with no
//           pop in the same cycle is dropped and sets the sticky ovf flag.
//
// Ports:
//   clk, rstn             clock and asynchronous active-low reset
//   seq                   single-cycle match pulse from the sequence detector
//   clr                   synchronous clear of all statistics; it overrides
//                         seq and pop in the same cycle
//   match_cnt             saturating count of matches
//   gap_valid/gap_ready   valid-ready handshake for gap_data
//   gap_data              oldest queued gap, first-word-fall-through
//   ovf                   sticky: at least one gap was dropped on a full FIFO

// Purpose : generic synchronous FIFO with first-word-fall-through read data.
// Latency : a write is visible on rd_vld/rd_dat the cycle after it is accepted.
// Backpr. : a write into a full FIFO is accepted only when a read happens in
//           the same cycle. Otherwise the write is ignored, and the caller
//           detects this through full.
module sync_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         clr,
   input  logic         wr_vld,
   input  logic [W-1:0] wr_dat,
   input  logic         rd_rdy,
   output logic         rd_vld,
   output logic [W-1:0] rd_dat,
   output logic         full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          rd_en;
   logic          wr_en;

   assign rd_vld = (count != '0);
   assign full   = (count == CNT_FULL);
   assign rd_dat = mem[rd_ptr];

   // clr wins over both ports. A pop frees the slot the push lands in, so a
   // full FIFO still accepts a push when a pop happens in the same cycle.
   assign rd_en = rd_vld && rd_rdy && !clr;
   assign wr_en = wr_vld && (!full || rd_en) && !clr;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         // Storage is cleared so that the head data reads as zero out of reset.
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= wr_dat;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (wr_en && !rd_en) begin
            count <= count + (AW+1)'(1);
         end else if (rd_en && !wr_en) begin
            count <= count - (AW+1)'(1);
         end
      end
   end

endmodule

module seq_match_monitor #(
   parameter int CNT_W = 16,
   parameter int GAP_W = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             seq,
   input  logic             clr,
   output logic [CNT_W-1:0] match_cnt,
   output logic             gap_valid,
   input  logic             gap_ready,
   output logic [GAP_W-1:0] gap_data,
   output logic             ovf
);

   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [GAP_W-1:0] GAP_MAX = '1;
   localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

   state_t           state;
   logic [GAP_W-1:0] gap_cnt;
   logic             push_vld;
   logic             pop;
   logic             fifo_full;

   // gap_cnt holds the distance from the last match to the current cycle.
   // Pushing it on the next match gives 1 for back-to-back pulses.
   assign push_vld = (state == ARMED) && seq && !clr;
   assign pop      = gap_valid && gap_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         gap_cnt <= '0;
      end else if (clr) begin
         state   <= IDLE;
         gap_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (seq) begin
                  state   <= ARMED;
                  gap_cnt <= GAP_ONE;
               end
            end
            ARMED: begin
               if (seq) begin
                  gap_cnt <= GAP_ONE;
               end else if (gap_cnt == GAP_MAX) begin
                  // The gap is too long to represent, so it is abandoned
                  // silently. The next match starts a fresh measurement.
                  state   <= IDLE;
                  gap_cnt <= '0;
               end else begin
                  gap_cnt <= gap_cnt + GAP_ONE;
               end
            end
            default: begin
               state   <= IDLE;
               gap_cnt <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         match_cnt <= '0;
      end else if (clr) begin
         match_cnt <= '0;
      end else if (seq && (match_cnt != CNT_MAX)) begin
         match_cnt <= match_cnt + CNT_W'(1);
      end
   end

   // The flag is set only when the push is really lost. A full FIFO that is
   // popped in the same cycle still takes the new entry.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovf <= 1'b0;
      end else if (clr) begin
         ovf <= 1'b0;
      end else if (push_vld && fifo_full && !pop) begin
         ovf <= 1'b1;
      end
   end

   sync_fifo #(
      .W     (GAP_W),
      .DEPTH (DEPTH)
   ) u_gap_fifo (
      .clk    (clk),
      .rstn   (rstn),
      .clr    (clr),
      .wr_vld (push_vld),
      .wr_dat (gap_cnt),
      .rd_rdy (gap_ready),
      .rd_vld (gap_valid),
      .rd_dat (gap_data),
      .full   (fifo_full)
   );

endmodule

// File: tb/tb_seq_match_monitor.sv
module tb_seq_match_monitor;

   localparam int CNT_W = 4;
   localparam int GAP_W = 4;
   localparam int DEPTH = 4;
   localparam int MAXC  = (1 << CNT_W) - 1;
   localparam int MAXG  = (1 << GAP_W) - 1;

   logic             clk;
   logic             rstn;
   logic             seq;
   logic             clr;
   logic [CNT_W-1:0] match_cnt;
   logic             gap_valid;
   logic             gap_ready;
   logic [GAP_W-1:0] gap_data;
   logic             ovf;

   int n_tests;
   int n_fail;

   // Reference model: the matches are kept as absolute cycle numbers, and
   // each gap is the difference between two of them. A gap is queued only
   // when it fits in GAP_W bits.
   int m_cyc;
   int m_last;
   int m_cnt;
   bit m_ovf;
   int m_q[$];

   seq_match_monitor #(
      .CNT_W (CNT_W),
      .GAP_W (GAP_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .seq       (seq),
      .clr       (clr),
      .match_cnt (match_cnt),
      .gap_valid (gap_valid),
      .gap_ready (gap_ready),
      .gap_data  (gap_data),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_last = -1;
      m_cnt  = 0;
      m_ovf  = 1'b0;
      m_q.delete();
   endtask

   task automatic model_step(input bit s, input bit r, input bit c);
      bit full;
      bit pop;
      bit push;
      int g;
      full = 1'b0;
      pop  = 1'b0;
      push = 1'b0;
      g    = 0;
      if (c) begin
         model_reset();
      end else begin
         full = (m_q.size() == DEPTH);
         pop  = (m_q.size() > 0) && r;
         if (s && (m_last >= 0) && ((m_cyc - m_last) <= MAXG)) begin
            push = 1'b1;
            g    = m_cyc - m_last;
         end
         if (s) begin
            if (m_cnt < MAXC) m_cnt++;
            m_last = m_cyc;
         end
         if (pop) void'(m_q.pop_front());
         if (push) begin
            if (full && !pop) m_ovf = 1'b1;
            else m_q.push_back(g);
         end
      end
      m_cyc++;
   endtask

   // Drive one clock cycle and advance the model. Outputs are then sampled
   // on the falling edge.
   task automatic tick(input bit s, input bit r, input bit c);
      seq       = s;
      gap_ready = r;
      clr       = c;
      @(posedge clk);
      model_step(s, r, c);
      @(negedge clk);
      seq       = 1'b0;
      gap_ready = 1'b0;
      clr       = 1'b0;
   endtask

   task automatic test_reset();
      rstn      = 1'b0;
      seq       = 1'b0;
      clr       = 1'b0;
      gap_ready = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++; if (match_cnt !== '0) begin n_fail++; $display("FAIL reset_match_cnt got %0d exp 0", match_cnt); end
      n_tests++; if (gap_valid !== 1'b0) begin n_fail++; $display("FAIL reset_gap_valid got %b exp 0", gap_valid); end
      n_tests++; if (gap_data !== '0) begin n_fail++; $display("FAIL reset_gap_data got %0d exp 0", gap_data); end
      n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", ovf); end
      model_reset();
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      tick(0, 0, 1);
      for (int i = 0; i < 8; i++) begin
         tick((i == 0) || (i == 1) || (i == 5), 1'b1, 1'b0);
         if (i == 0) begin
            n_tests++; if (gap_valid !== 1'b0) begin n_fail++; $display("FAIL basic_first_no_push got %b exp 0", gap_valid); end
         end
         if (i == 1) begin
            n_tests++; if (gap_valid !== 1'b1 || gap_data !== 4'd1) begin n_fail++; $display("FAIL basic_gap1 got v=%b d=%0d exp v=1 d=1", gap_valid, gap_data); end
         end
         if (i == 2) begin
            n_tests++; if (gap_valid !== 1'b0) begin n_fail++; $display("FAIL basic_popped got %b exp 0", gap_valid); end
         end
         if (i == 5) begin
            n_tests++; if (gap_valid !== 1'b1 || gap_data !== 4'd4) begin n_fail++; $display("FAIL basic_gap4 got v=%b d=%0d exp v=1 d=4", gap_valid, gap_data); end
         end
      end
      n_tests++; if (match_cnt !== 4'd3) begin n_fail++; $display("FAIL basic_match_cnt got %0d exp 3", match_cnt); end
   endtask

   task automatic test_overflow();
      int seen;
      tick(0, 0, 1);
      tick(1, 0, 0);
      for (int g = 1; g <= 6; g++) begin
         repeat (g - 1) tick(0, 0, 0);
         tick(1, 0, 0);
      end
      n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", ovf); end
      n_tests++; if (gap_data !== 4'd1) begin n_fail++; $display("FAIL ovf_head got %0d exp 1", gap_data); end
      n_tests++; if (match_cnt !== 4'd7) begin n_fail++; $display("FAIL ovf_match_cnt got %0d exp 7", match_cnt); end
      seen = 0;
      for (int i = 0; i < 10 && gap_valid === 1'b1; i++) begin
         n_tests++; if (gap_data !== GAP_W'(seen + 1)) begin n_fail++; $display("FAIL ovf_order[%0d] got %0d exp %0d", seen, gap_data, seen + 1); end
         seen++;
         tick(0, 1, 0);
      end
      n_tests++; if (seen != 4) begin n_fail++; $display("FAIL ovf_occupancy got %0d exp 4", seen); end
      n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
   endtask

   task automatic test_full_pop();
      int exp_g[4];
      int seen;
      exp_g = '{1, 1, 1, 3};
      tick(0, 0, 1);
      repeat (5) tick(1, 0, 0);
      repeat (2) tick(0, 0, 0);
      tick(1, 1, 0);
      n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovf got %b exp 0", ovf); end
      seen = 0;
      for (int i = 0; i < 10 && gap_valid === 1'b1; i++) begin
         if (seen < 4) begin
            n_tests++; if (gap_data !== GAP_W'(exp_g[seen])) begin n_fail++; $display("FAIL fullpop_entry[%0d] got %0d exp %0d", seen, gap_data, exp_g[seen]); end
         end
         seen++;
         tick(0, 1, 0);
      end
      n_tests++; if (seen != 4) begin n_fail++; $display("FAIL fullpop_occupancy got %0d exp 4", seen); end
   endtask

   task automatic test_timeout();
      tick(0, 0, 1);
      tick(1, 0, 0);
      repeat (19) tick(0, 0, 0);
      tick(1, 0, 0);
      n_tests++; if (gap_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_no_push got %b exp 0", gap_valid); end
      repeat (2) tick(0, 0, 0);
      tick(1, 0, 0);
      n_tests++; if (gap_valid !== 1'b1 || gap_data !== 4'd3) begin n_fail++; $display("FAIL timeout_gap3 got v=%b d=%0d exp v=1 d=3", gap_valid, gap_data); end
      tick(0, 1, 0);
      repeat (13) tick(0, 0, 0);
      tick(1, 0, 0);
      n_tests++; if (gap_valid !== 1'b1 || gap_data !== 4'd15) begin n_fail++; $display("FAIL timeout_gap_max got v=%b d=%0d exp v=1 d=15", gap_valid, gap_data); end
      tick(0, 1, 0);
      repeat (14) tick(0, 0, 0);
      tick(1, 0, 0);
      n_tests++; if (gap_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_gap16 got %b exp 0", gap_valid); end
      n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL timeout_ovf got %b exp 0", ovf); end
   endtask

   task automatic test_clr();
      tick(0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         tick(1, 0, 0);
         repeat (19) tick(0, 0, 0);
      end
      repeat (3) tick(1, 0, 0);
      n_tests++; if (match_cnt !== 4'd7 || gap_valid !== 1'b1) begin n_fail++; $display("FAIL clr_setup got cnt=%0d v=%b exp cnt=7 v=1", match_cnt, gap_valid); end
      tick(1, 1, 1);
      n_tests++; if (match_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_match_cnt got %0d exp 0", match_cnt); end
      n_tests++; if (gap_valid !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL clr_fifo got v=%b ovf=%b exp 0 0", gap_valid, ovf); end
      tick(1, 0, 0);
      n_tests++; if (match_cnt !== 4'd1 || gap_valid !== 1'b0) begin n_fail++; $display("FAIL clr_idle got cnt=%0d v=%b exp cnt=1 v=0", match_cnt, gap_valid); end
      tick(0, 0, 0);
      tick(1, 0, 0);
      n_tests++; if (gap_valid !== 1'b1 || gap_data !== 4'd2) begin n_fail++; $display("FAIL clr_after_gap got v=%b d=%0d exp v=1 d=2", gap_valid, gap_data); end
   endtask

   task automatic test_async_reset();
      tick(0, 0, 1);
      repeat (3) tick(1, 0, 0);
      repeat (2) tick(0, 0, 0);
      #2 rstn = 1'b0;
      #1;
      n_tests++; if (match_cnt !== '0 || ovf !== 1'b0) begin n_fail++; $display("FAIL arst_regs got cnt=%0d ovf=%b exp 0 0", match_cnt, ovf); end
      n_tests++; if (gap_valid !== 1'b0 || gap_data !== '0) begin n_fail++; $display("FAIL arst_fifo got v=%b d=%0d exp 0 0", gap_valid, gap_data); end
      model_reset();
      #1 rstn = 1'b1;
      @(negedge clk);
      tick(1, 0, 0);
      n_tests++; if (match_cnt !== 4'd1 || gap_valid !== 1'b0) begin n_fail++; $display("FAIL arst_first got cnt=%0d v=%b exp 1 0", match_cnt, gap_valid); end
      tick(1, 0, 0);
      n_tests++; if (gap_valid !== 1'b1 || gap_data !== 4'd1) begin n_fail++; $display("FAIL arst_second got v=%b d=%0d exp 1 1", gap_valid, gap_data); end
   endtask

   task automatic test_saturation();
      tick(0, 0, 1);
      repeat (14) tick(1, 1, 0);
      n_tests++; if (match_cnt !== 4'd14) begin n_fail++; $display("FAIL sat_below got %0d exp 14", match_cnt); end
      repeat (6) tick(1, 1, 0);
      n_tests++; if (match_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold got %0d exp 15", match_cnt); end
   endtask

   task automatic test_random();
      int spct;
      int rpct;
      bit s;
      bit r;
      bit c;
      logic [CNT_W-1:0] e_cnt;
      logic [GAP_W-1:0] e_dat;
      tick(0, 0, 1);
      for (int i = 0; i < 3000; i++) begin
         spct = ((i / 250) % 2 == 1) ? 45 : 6;
         rpct = ((i / 400) % 2 == 1) ? 15 : 70;
         s = ($urandom_range(0, 99) < spct);
         r = ($urandom_range(0, 99) < rpct);
         c = ($urandom_range(0, 499) == 0);
         tick(s, r, c);
         e_cnt = m_cnt[CNT_W-1:0];
         n_tests++; if (match_cnt !== e_cnt) begin n_fail++; $display("FAIL rand_match_cnt cyc %0d got %0d exp %0d", i, match_cnt, e_cnt); end
         n_tests++; if (gap_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rand_gap_valid cyc %0d got %b exp %b", i, gap_valid, m_q.size() != 0); end
         if (m_q.size() != 0) begin
            e_dat = GAP_W'(m_q[0]);
            n_tests++; if (gap_data !== e_dat) begin n_fail++; $display("FAIL rand_gap_data cyc %0d got %0d exp %0d", i, gap_data, e_dat); end
         end
         n_tests++; if (ovf !== m_ovf) begin n_fail++; $display("FAIL rand_ovf cyc %0d got %b exp %b", i, ovf, m_ovf); end
      end
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      m_cyc     = 0;
      rstn      = 1'b0;
      seq       = 1'b0;
      clr       = 1'b0;
      gap_ready = 1'b0;
      model_reset();
      test_reset();
      test_basic();
      test_overflow();
      test_full_pop();
      test_timeout();
      test_clr();
      test_async_reset();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
